// File: rtl/fetch_unpack.sv
// Instruction fetch front end: issues 64-bit aligned reads, buffers returned beats
// and hands out 32-bit instructions with their PC until a zero beat ends the stream.
module fetch_unpack #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] entry,
  input  logic        start,
  output logic        req_valid,
  output logic [63:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  output logic        insn_valid,
  output logic [31:0] insn,
  output logic [63:0] insn_pc,
  input  logic        insn_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state, w_state_n;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr, w_wptr_n, w_rptr_n;
  logic [CW-1:0] r_count, r_out, w_count_n, w_out_n;
  logic [63:0]   r_fetch_addr, w_fetch_addr_n;
  logic [63:0]   r_pc, w_pc_n;
  logic          r_hi, w_hi_n;
  logic          r_req_valid, w_req_valid_n;
  logic          r_insn_valid;
  logic [31:0]   r_insn, w_insn_n;
  logic          r_busy, r_done;
  logic [63:0]   w_head;
  logic          w_start, w_acc, w_resp, w_term, w_push, w_consume, w_pop;

  always_comb begin
    w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_acc     = r_req_valid && req_ready;
    w_resp    = resp_valid && (r_out != '0);
    w_term    = w_resp && (r_state == S_FETCH) && (resp_data == '0);
    w_push    = w_resp && (r_state == S_FETCH) && (resp_data != '0);
    // r_insn_valid always mirrors a non-empty buffer; r_hi selects which half of the head is shown
    w_consume = r_insn_valid && insn_ready;
    w_pop     = w_consume && r_hi;
  end

  always_comb begin
    w_out_n        = r_out + CW'(w_acc) - CW'(w_resp);
    w_count_n      = r_count + CW'(w_push) - CW'(w_pop);
    w_rptr_n       = r_rptr + AW'(w_pop);
    w_wptr_n       = r_wptr + AW'(w_push);
    w_fetch_addr_n = w_acc ? (r_fetch_addr + 64'd8) : r_fetch_addr;
    w_pc_n         = w_consume ? (r_pc + 64'd4) : r_pc;
    w_hi_n         = w_pop ? 1'b0 : (w_consume ? 1'b1 : r_hi);
    // Next head is the beat arriving now when the buffer runs dry this cycle
    w_head         = ((r_count - CW'(w_pop)) == '0) ? resp_data : r_mem[w_rptr_n];
    w_insn_n       = w_hi_n ? w_head[63:32] : w_head[31:0];
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_n = S_FETCH;
      S_FETCH: if (w_term) w_state_n = S_DRAIN;
      S_DRAIN: if ((r_out == '0) && (r_count == '0)) w_state_n = S_DONE;
      S_DONE:  if (start) w_state_n = S_FETCH;
      default: w_state_n = S_IDLE;
    endcase
    w_req_valid_n = (w_state_n == S_FETCH) &&
                    (({1'b0, w_out_n} + {1'b0, w_count_n}) < (CW + 1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_fetch_addr <= '0;
      r_pc         <= '0;
      r_hi         <= 1'b0;
      r_out        <= '0;
      r_count      <= '0;
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_req_valid  <= 1'b0;
      r_insn_valid <= 1'b0;
      r_insn       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_start) begin
      r_state      <= S_FETCH;
      r_fetch_addr <= {entry[63:3], 3'b000};
      r_pc         <= entry;
      r_hi         <= entry[2];
      r_out        <= '0;
      r_count      <= '0;
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_req_valid  <= 1'b1;
      r_insn_valid <= 1'b0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_fetch_addr <= w_fetch_addr_n;
      r_pc         <= w_pc_n;
      r_hi         <= w_hi_n;
      r_out        <= w_out_n;
      r_count      <= w_count_n;
      r_rptr       <= w_rptr_n;
      r_wptr       <= w_wptr_n;
      r_req_valid  <= w_req_valid_n;
      r_insn_valid <= (w_count_n != '0);
      if (w_count_n != '0) r_insn <= w_insn_n;
      r_busy       <= (w_state_n == S_FETCH) || (w_state_n == S_DRAIN);
      r_done       <= (w_state_n == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= resp_data;
  end

  assign req_valid  = r_req_valid;
  assign req_addr   = r_fetch_addr;
  assign insn_valid = r_insn_valid;
  assign insn       = r_insn;
  assign insn_pc    = r_pc;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_fetch_unpack.sv
// Bench for fetch_unpack: memory responder, stream model built from the memory image,
// and a single negedge monitor comparing DUT traffic against the model.
module tb_fetch_unpack;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        start;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        insn_valid;
  logic [31:0] insn;
  logic [63:0] insn_pc;
  logic        insn_ready;
  logic        busy;
  logic        done;

  fetch_unpack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .entry(entry), .start(start),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc), .insn_ready(insn_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] w;
  } insn_t;

  logic [63:0] img [logic [63:0]];
  insn_t       exp_q[$];
  logic [63:0] pending[$];
  logic [63:0] acc_log[$];
  logic [63:0] t3_addr [4] = '{64'h1000, 64'h1008, 64'h1010, 64'h1018};

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned m_out = 0, m_push = 0, m_pop = 0, n_disc = 0, n_emit = 0;
  bit          m_term = 1'b0, mon_en = 1'b0, stray = 1'b0;
  logic [63:0] m_next_addr = '0;
  insn_t       first_seen, last_seen;
  int unsigned ir_mode = 1, rr_mode = 1, gap = 0, cyc = 0;

  function automatic logic [63:0] memrd(input logic [63:0] a);
    if (img.exists(a)) return img[a];
    return {a[31:0] | 32'h1, ~a[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Expected instruction stream: walk the image beat by beat until a zero beat
  function automatic void build_exp(input logic [63:0] e);
    logic [63:0] a, d;
    insn_t t;
    exp_q.delete();
    a = {e[63:3], 3'b000};
    for (int i = 0; i < 64; i++) begin
      d = memrd(a);
      if (d == 64'h0) break;
      if (!(i == 0 && e[2])) begin
        t.pc = a; t.w = d[31:0]; exp_q.push_back(t);
      end
      t.pc = a + 64'd4; t.w = d[63:32]; exp_q.push_back(t);
      a = a + 64'd8;
    end
  endfunction

  // Input driver: handshake readiness patterns and in-order memory responses
  initial begin
    insn_ready = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      insn_ready = (ir_mode == 1) ? 1'b1 : (ir_mode == 2) ? ((cyc % 3) != 0) : 1'b0;
      req_ready  = (rr_mode == 1) ? 1'b1 : ((cyc % 4) != 1);
      if (stray) begin
        resp_valid = 1'b1; resp_data = 64'h1234_5678_9ABC_DEF0; stray = 1'b0;
      end else if (pending.size() > 0 && (cyc % (gap + 1)) == 0) begin
        resp_valid = 1'b1; resp_data = memrd(pending.pop_front());
      end else begin
        resp_valid = 1'b0; resp_data = 64'hCAFE_F00D_CAFE_F00D;
      end
    end
  end

  // Monitor: one comparison pass per cycle, away from the clock edge
  initial begin
    insn_t       e;
    bit          p_hold, p_rhold;
    logic [31:0] p_insn;
    logic [63:0] p_pc, p_raddr;
    p_hold = 1'b0; p_rhold = 1'b0; p_insn = '0; p_pc = '0; p_raddr = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        p_hold = 1'b0; p_rhold = 1'b0;
        continue;
      end
      if (p_hold) begin
        check("insn_hold_valid", insn_valid, 1);
        check("insn_hold_word", insn, p_insn);
        check("insn_hold_pc", insn_pc, p_pc);
      end
      if (p_rhold) begin
        check("req_hold_valid", req_valid, 1);
        check("req_hold_addr", req_addr, p_raddr);
      end
      if (insn_valid && insn_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_insn: got pc %h insn %h, required no instruction", insn_pc, insn);
        end else begin
          e = exp_q.pop_front();
          check("insn_pc", insn_pc, e.pc);
          check("insn_word", insn, e.w);
        end
        if (n_emit == 0) begin first_seen.pc = insn_pc; first_seen.w = insn; end
        last_seen.pc = insn_pc; last_seen.w = insn;
        n_emit++;
        if (insn_pc[2]) m_pop++;
      end
      if (req_valid) check("credit", (m_out + m_push - m_pop) < DEPTH, 1);
      if (resp_valid && m_out > 0) begin
        m_out--;
        if (m_term) n_disc++;
        else if (resp_data == 64'h0) m_term = 1'b1;
        else m_push++;
      end
      if (req_valid && req_ready) begin
        check("req_addr", req_addr, m_next_addr);
        m_next_addr = m_next_addr + 64'd8;
        pending.push_back(req_addr);
        acc_log.push_back(req_addr);
        m_out++;
      end
      if (done) begin
        check("done_no_outstanding", pending.size(), 0);
        check("done_not_busy", busy, 0);
      end
      p_hold  = insn_valid && !insn_ready; p_insn = insn; p_pc = insn_pc;
      p_rhold = req_valid && !req_ready && !m_term; p_raddr = req_addr;
    end
  end

  task automatic run_start(input logic [63:0] e);
    @(posedge clk); #2;
    build_exp(e);
    m_out = 0; m_push = 0; m_pop = 0; n_disc = 0; n_emit = 0; m_term = 1'b0;
    m_next_addr = {e[63:3], 3'b000};
    pending.delete(); acc_log.delete();
    entry = e; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_req_valid", req_valid, 1);
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned k;
    k = 0;
    while (!done && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    check("done_reached", done, 1);
    check("stream_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_req_addr"}, req_addr, 0);
    check({tag, "_insn_valid"}, insn_valid, 0);
    check({tag, "_insn"}, insn, 0);
    check({tag, "_insn_pc"}, insn_pc, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int unsigned k;
    reset = 1'b0; entry = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(posedge clk); #2;
    reset = 1'b1;
    mon_en = 1'b1;

    // Basic two-instruction program
    img.delete();
    img[64'h1000] = 64'h00A00593_00500513;
    img[64'h1008] = 64'h0;
    run_start(64'h1000);
    wait_done(200);
    check("t1_first_pc", first_seen.pc, 64'h1000);
    check("t1_first_insn", first_seen.w, 32'h00500513);
    check("t1_count", n_emit, 2);

    // Entry on the upper half of a beat
    run_start(64'h1004);
    wait_done(200);
    check("t2_first_pc", first_seen.pc, 64'h1004);
    check("t2_first_insn", first_seen.w, 32'h00A00593);
    check("t2_count", n_emit, 1);

    // Credit limit with a stalled decoder, then stalls on both sides
    img.delete();
    for (int i = 0; i < 6; i++)
      img[64'h1000 + 64'(8 * i)] = {32'hB000_0000 + 32'(2 * i + 1), 32'hA000_0000 + 32'(2 * i)};
    img[64'h1030] = 64'h0;
    ir_mode = 0; rr_mode = 1; gap = 0;
    run_start(64'h1000);
    @(posedge clk); #2;
    entry = 64'h5000; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("t3_req_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (acc_log.size() > i) check("t3_req_seq", acc_log[i], t3_addr[i]);
    check("t3_req_stalled", req_valid, 0);
    check("t3_head_valid", insn_valid, 1);
    check("t3_head_pc", insn_pc, 64'h1000);
    check("t3_head_insn", insn, 32'hA000_0000);
    ir_mode = 2; rr_mode = 2;
    wait_done(400);
    check("t3_count", n_emit, 12);
    ir_mode = 1; rr_mode = 1;

    // Zero upper half inside a non-zero beat, then a stray response in DONE
    img.delete();
    img[64'h1000] = 64'h00000000_00000013;
    img[64'h1008] = 64'h0;
    run_start(64'h1000);
    wait_done(200);
    check("t4_count", n_emit, 2);
    check("t4_first_pc", first_seen.pc, 64'h1000);
    check("t4_first_insn", first_seen.w, 32'h13);
    check("t4_last_pc", last_seen.pc, 64'h1004);
    check("t4_last_insn", last_seen.w, 32'h0);
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("stray_no_insn", insn_valid, 0);
    check("stray_done", done, 1);

    // Terminator arrives with two requests still in flight
    img.delete();
    img[64'h1000] = 64'h00A00593_00500513;
    img[64'h1008] = 64'h0;
    ir_mode = 0; gap = 2;
    run_start(64'h1000);
    k = 0;
    while (!m_term && k < 100) begin
      @(posedge clk); #2;
      k++;
    end
    check("t5_term_seen", m_term, 1);
    check("t5_in_flight", pending.size(), 2);
    ir_mode = 1;
    wait_done(300);
    check("t5_discarded", n_disc, 2);
    check("t5_count", n_emit, 2);
    gap = 0;

    // Reset in the middle of a filled buffer, then a fresh program
    img.delete();
    for (int i = 0; i < 6; i++)
      img[64'h2000 + 64'(8 * i)] = {32'hD000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
    img[64'h2030] = 64'h0;
    ir_mode = 0;
    run_start(64'h2000);
    k = 0;
    while (m_push < 3 && k < 100) begin
      @(posedge clk); #2;
      k++;
    end
    check("t6_three_buffered", m_push >= 3, 1);
    check("t6_pre_valid", insn_valid, 1);
    @(posedge clk); #3;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_all_zero("t6_async");
    pending.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;
    img.delete();
    img[64'h3000] = 64'h22222222_11111111;
    img[64'h3008] = 64'h44444444_33333333;
    img[64'h3010] = 64'h0;
    ir_mode = 1;
    run_start(64'h3000);
    wait_done(200);
    check("t6_first_pc", first_seen.pc, 64'h3000);
    check("t6_first_insn", first_seen.w, 32'h11111111);
    check("t6_count", n_emit, 4);
    check("t6_last_insn", last_seen.w, 32'h44444444);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unpack.md
FETCH_UNPACK -- requirements
Module: fetch_unpack

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of 64-bit beat buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port entry  input  64  start PC, sampled on start; bits[1:0] must be 0.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins fetching at entry.
REQ-006 SHALL have port req_valid  output  1  memory read request valid.
REQ-007 SHALL have port req_addr  output  64  8-byte-aligned read address, stable while req_valid && !req_ready.
REQ-008 SHALL have port req_ready  input  1  memory accepts the request this cycle.
REQ-009 SHALL have port resp_valid  input  1  one 64-bit read beat; memory returns beats in request order.
REQ-010 SHALL have port resp_data  input  64  read beat; bits[31:0] hold the instruction at the lower address.
REQ-011 SHALL have port insn_valid  output  1  instruction word valid to the decoder.
REQ-012 SHALL have port insn  output  32  instruction word.
REQ-013 SHALL have port insn_pc  output  64  PC of insn.
REQ-014 SHALL have port insn_ready  input  1  decoder consumes insn this cycle.
REQ-015 SHALL have port busy  output  1  high in FETCH or DRAIN.
REQ-016 SHALL have port done  output  1  high in DONE.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start; FETCH->DRAIN on a terminating beat; DRAIN->DONE when outstanding==0 and buffer empty; DONE->FETCH on start.
REQ-018 SHALL ignore start in FETCH and DRAIN.
REQ-019 On start SHALL load fetch address = {entry[63:3],3'b0} and output PC = entry, and clear buffer and counters.
REQ-020 SHALL assert req_valid in FETCH only when outstanding + buffer occupancy < DEPTH (credit rule), so the buffer never overflows.
REQ-021 Each accepted request (req_valid && req_ready) SHALL increment fetch address by 8 (64-bit wrap) and outstanding by 1.
REQ-022 Each resp_valid SHALL decrement outstanding; resp_valid with outstanding==0 SHALL be ignored.
REQ-023 A beat with resp_data==64'h0 in FETCH SHALL be terminating: not buffered, req_valid drops next cycle, state goes to DRAIN.
REQ-024 In DRAIN, later responses SHALL be discarded; buffered beats before the terminator SHALL still be emitted.
REQ-025 Non-terminating beats SHALL be pushed into the buffer; push and pop in the same cycle SHALL be allowed.
REQ-026 Each beat SHALL emit resp_data[31:0] at PC then resp_data[63:32] at PC+4; a zero half inside a non-zero beat SHALL still be emitted.
REQ-027 If entry[2]==1, the low half of the first beat SHALL be skipped and its high half emitted first at PC=entry.
REQ-028 insn, insn_pc, insn_valid SHALL be driven from registers; insn_valid && !insn_ready SHALL hold all three stable.
REQ-029 On insn_valid && insn_ready, PC SHALL advance by 4; the beat SHALL be popped after its high half is consumed.
REQ-030 Latency: start at cycle 0 -> req_valid at cycle 1; beat into empty buffer at cycle N -> insn_valid at N+1.
REQ-031 With insn_ready held 1 and one beat per cycle, SHALL sustain one instruction per cycle (requests stall when credit exhausted).

Reset
REQ-032 While reset==0, SHALL be in IDLE with req_valid=0, req_addr=0, insn_valid=0, insn=0, insn_pc=0, busy=0, done=0, buffer empty, outstanding=0.
REQ-033 Reset assertion mid-operation SHALL abort immediately, discarding outstanding requests and buffered beats; start after release begins fresh.

Verification
REQ-034 entry=0x1000, memory 0x1000=0x00A00593_00500513, 0x1008=0x0, insn_ready=1 -> insns (0x1000,0x00500513),(0x1004,0x00A00593), then done=1.
REQ-035 entry=0x1004, same image -> first insn (0x1004,0x00A00593), no insn at 0x1000, then done.
REQ-036 DEPTH=4, insn_ready=0, req_ready=1 -> exactly 4 requests (0x1000..0x1018) issued, then req_valid=0 until a beat is popped.
REQ-037 Beat 0x00000000_00000013 at 0x1000 -> emits (0x1000,0x13) and (0x1004,0x0); not terminating.
REQ-038 Terminator at 0x1008 with 2 requests still outstanding -> those responses discarded, done only after outstanding==0.
REQ-039 reset=0 asserted with insn_valid=1 and 3 beats buffered -> all outputs 0 asynchronously; start after release fetches from new entry only.
